// File: rtl/alu_retry_sequencer_pkg.sv
// Shared encodings for the ALU retry sequencer.
// States, status codes, one-hot ops and the two-rail good code.
package alu_retry_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_FLUSH,
    ST_RESP
  } state_e;

  localparam logic [1:0] STAT_OK        = 2'b00;
  localparam logic [1:0] STAT_OK_RETRY  = 2'b01;
  localparam logic [1:0] STAT_INPUT_ERR = 2'b10;
  localparam logic [1:0] STAT_FAIL      = 2'b11;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB_AB = 3'b010;
  localparam logic [2:0] OP_SUB_BA = 3'b100;

  localparam logic [1:0] ERR_OK = 2'b10;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_retry_sequencer_req_check.sv
// Request pre-check: odd parity over {a,b,par} and one-hot op.
// Purely combinational; req_bad high blocks issue to the datapath.
module alu_req_check
  import alu_retry_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             par,
  input  logic [2:0]       op,
  output logic             req_bad
);

  logic par_ok;
  logic op_ok;

  always_comb begin
    par_ok = ^{a, b, par};
    op_ok  = (op == OP_ADD)
          || (op == OP_SUB_AB)
          || (op == OP_SUB_BA);
    req_bad = !par_ok || !op_ok;
  end

endmodule

// File: rtl/alu_retry_sequencer.sv
// Issues checked requests to the duplicated ALU datapath,
// compares both copies and retries transient faults.
module alu_retry_sequencer
  import alu_retry_sequencer_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int MAX_RETRY     = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_par,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_par,
  output logic [2:0]       dp_c,
  input  logic [WIDTH-1:0] dp_x,
  input  logic [WIDTH-1:0] dp_y,
  input  logic             dp_xc,
  input  logic             dp_yc,
  input  logic [1:0]       dp_xe,
  input  logic [1:0]       dp_ye,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [1:0]       rsp_status,
  output logic [7:0]       err_count
);

  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);
  localparam int SW = (SETTLE_CYCLES < 2) ? 1
                    : $clog2(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [2:0]       op_q, op_d;
  logic             req_ready_q, req_ready_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d;
  logic [WIDTH-1:0] dp_b_q, dp_b_d;
  logic             dp_par_q, dp_par_d;
  logic [2:0]       dp_c_q, dp_c_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [7:0]       err_count_q, err_count_d;

  logic req_bad;
  logic chk_pass;

  alu_req_check #(
    .WIDTH (WIDTH)
  ) u_req_check (
    .a       (req_a),
    .b       (req_b),
    .par     (req_par),
    .op      (req_op),
    .req_bad (req_bad)
  );

  assign chk_pass = (dp_xe == ERR_OK)
                 && (dp_ye == ERR_OK)
                 && (dp_x == dp_y)
                 && (dp_xc == dp_yc);

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    settle_d     = settle_q;
    op_d         = op_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_par_d     = dp_par_q;
    dp_c_d       = dp_c_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_status_d = rsp_status_q;
    err_count_d  = err_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_bad) begin
            rsp_status_d = STAT_INPUT_ERR;
            rsp_result_d = '0;
            rsp_carry_d  = 1'b0;
            state_d      = ST_RESP;
          end else begin
            dp_a_d   = req_a;
            dp_b_d   = req_b;
            dp_par_d = req_par;
            dp_c_d   = req_op;
            op_d     = req_op;
            retry_d  = '0;
            settle_d = '0;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_CHECK: begin
        if (chk_pass) begin
          rsp_result_d = dp_x;
          rsp_carry_d  = dp_xc;
          rsp_status_d = (retry_q == '0) ? STAT_OK
                                         : STAT_OK_RETRY;
          state_d      = ST_RESP;
        end else begin
          err_count_d = sat_inc8(err_count_q);
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            dp_c_d  = OP_NONE;
            state_d = ST_FLUSH;
          end else begin
            rsp_result_d = '0;
            rsp_carry_d  = 1'b0;
            rsp_status_d = STAT_FAIL;
            state_d      = ST_RESP;
          end
        end
      end
      // Dropping C for a cycle re-excites a transient fault
      ST_FLUSH: begin
        dp_c_d   = op_q;
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          dp_a_d   = '0;
          dp_b_d   = '0;
          dp_par_d = 1'b0;
          dp_c_d   = OP_NONE;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      settle_q     <= '0;
      op_q         <= OP_NONE;
      req_ready_q  <= 1'b1;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_par_q     <= 1'b0;
      dp_c_q       <= OP_NONE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_status_q <= STAT_OK;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      settle_q     <= settle_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_par_q     <= dp_par_d;
      dp_c_q       <= dp_c_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_status_q <= rsp_status_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_par     = dp_par_q;
  assign dp_c       = dp_c_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_status = rsp_status_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_retry_sequencer.sv
// Directed bench for alu_retry_sequencer with a behavioural
// duplicated-ALU model and fault injection knobs.
module tb_alu_retry_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_a = '0;
  logic [2:0] req_b = '0;
  logic       req_par = 1'b0;
  logic [2:0] req_op = '0;
  logic [2:0] dp_a, dp_b, dp_c;
  logic       dp_par;
  logic [2:0] dp_x, dp_y;
  logic       dp_xc, dp_yc;
  logic [1:0] dp_xe, dp_ye;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_result;
  logic       rsp_carry;
  logic [1:0] rsp_status;
  logic [7:0] err_count;

  logic inject_xe = 1'b0;
  logic mismatch  = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int dpc_cnt   = 0;
  int flush_cnt = 0;

  always #5 clk = ~clk;

  alu_retry_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_par    (req_par),
    .req_op     (req_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_par     (dp_par),
    .dp_c       (dp_c),
    .dp_x       (dp_x),
    .dp_y       (dp_y),
    .dp_xc      (dp_xc),
    .dp_yc      (dp_yc),
    .dp_xe      (dp_xe),
    .dp_ye      (dp_ye),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_status (rsp_status),
    .err_count  (err_count)
  );

  // Behavioural duplicated ALU; carry on subtract = no borrow
  logic [3:0] sum;
  always_comb begin
    sum = 4'd0;
    case (dp_c)
      3'b001: sum = {1'b0, dp_a} + {1'b0, dp_b};
      3'b010: sum = {1'b0, dp_a} + {1'b0, ~dp_b} + 4'd1;
      3'b100: sum = {1'b0, dp_b} + {1'b0, ~dp_a} + 4'd1;
      default: sum = 4'd0;
    endcase
    dp_x  = sum[2:0];
    dp_xc = sum[3];
    dp_y  = sum[2:0] ^ {2'b00, mismatch};
    dp_yc = sum[3];
    dp_xe = inject_xe ? 2'b11 : 2'b10;
    dp_ye = 2'b10;
  end

  always @(negedge clk) begin
    if (dp_c != 3'b000) dpc_cnt <= dpc_cnt + 1;
    if (!rst && dp_c == 3'b000 && !req_ready && !rsp_valid)
      flush_cnt <= flush_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] a,
                      input logic [2:0] b,
                      input logic p,
                      input logic [2:0] op);
    req_a = a; req_b = b; req_par = p; req_op = op;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int snap;
    logic [2:0] r0;
    logic [1:0] s0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp_c", dp_c, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_err", err_count, 0);

    // 1: plain add
    send(3'b011, 3'b010, 1'b0, 3'b001);
    chk("t1_dp_c", dp_c, 3'b001);
    wait_rsp(lat);
    chk("t1_lat", lat, 2);
    chk("t1_res", rsp_result, 3'b101);
    chk("t1_carry", rsp_carry, 0);
    chk("t1_stat", rsp_status, 2'b00);
    chk("t1_err", err_count, 0);
    take();
    chk("t1_idle", req_ready, 1);
    chk("t1_dp_clr", dp_a, 0);

    // 2: even parity
    snap = dpc_cnt;
    send(3'b011, 3'b010, 1'b1, 3'b001);
    wait_rsp(lat);
    chk("t2_lat", lat, 0);
    chk("t2_stat", rsp_status, 2'b10);
    chk("t2_res", rsp_result, 0);
    take();
    chk("t2_dpc", dpc_cnt - snap, 0);

    // 3: bad op then valid B-A
    send(3'b001, 3'b001, 1'b1, 3'b011);
    wait_rsp(lat);
    chk("t3_stat", rsp_status, 2'b10);
    take();
    send(3'b010, 3'b001, 1'b1, 3'b100);
    wait_rsp(lat);
    chk("t3b_lat", lat, 2);
    chk("t3b_res", rsp_result, 3'b111);
    chk("t3b_carry", rsp_carry, 0);
    chk("t3b_stat", rsp_status, 2'b00);
    take();

    // 4: one transient error-rail fault
    snap = flush_cnt;
    inject_xe = 1'b1;
    send(3'b101, 3'b011, 1'b1, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_flush_c", dp_c, 3'b000);
    inject_xe = 1'b0;
    wait_rsp(lat);
    chk("t4_lat", lat, 3);
    chk("t4_res", rsp_result, 3'b010);
    chk("t4_carry", rsp_carry, 1);
    chk("t4_stat", rsp_status, 2'b01);
    chk("t4_err", err_count, 1);
    chk("t4_nflush", flush_cnt - snap, 1);
    take();

    // 5: persistent mismatch from a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    snap = flush_cnt;
    mismatch = 1'b1;
    send(3'b001, 3'b010, 1'b1, 3'b001);
    wait_rsp(lat);
    mismatch = 1'b0;
    chk("t5_lat", lat, 8);
    chk("t5_stat", rsp_status, 2'b11);
    chk("t5_res", rsp_result, 0);
    chk("t5_carry", rsp_carry, 0);
    chk("t5_err", err_count, 3);
    chk("t5_nflush", flush_cnt - snap, 2);

    // 6: backpressure hold
    r0 = rsp_result;
    s0 = rsp_status;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t6_hold_v", rsp_valid, 1);
      chk("t6_hold_s", {r0, s0}, {rsp_result, rsp_status});
      chk("t6_rdy", req_ready, 0);
    end
    chk("t6_stat", rsp_status, 2'b11);
    take();

    // 6b: reset during SETTLE
    send(3'b011, 3'b010, 1'b0, 3'b001);
    chk("t6b_busy", req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6b_rdy", req_ready, 1);
    chk("t6b_dp_c", dp_c, 0);
    chk("t6b_dp_a", dp_a, 0);
    chk("t6b_valid", rsp_valid, 0);
    chk("t6b_err", err_count, 0);
    chk("t6b_stat", rsp_status, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
